// File: rtl/cache_axi_pkg.sv
// Shared types and constants for the cache-to-AXI arbiter.
// Holds the arbiter state enum, requester ID, line/word types and the
// fixed AXI burst attributes used by cache_axi_arbiter and axi_line_buf.
package cache_axi_pkg;

  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned BCNT_W     = $clog2(LINE_WORDS);
  localparam int unsigned IDLE_GAP   = 2;
  localparam int unsigned GAP_W      = $clog2(IDLE_GAP + 1);

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [7:0] BURST_LEN  = 8'(LINE_WORDS - 1);
  localparam logic [3:0] WSEL_ALL   = 4'b1111;

  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(LINE_WORDS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } req_id_e;

  typedef logic [WORD_W-1:0]                  word_t;
  typedef logic [LINE_WORDS-1:0][WORD_W-1:0]  line_t;

endpackage

// File: rtl/axi_line_buf.sv
// One cache line of storage shared by refills and writebacks.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears the line)
//   load, load_line   full-line load (writeback capture)
//   wr_en, wr_idx,    single-word write (refill beat assembly)
//   wr_word
//   rd_idx, rd_word   word-indexed read mux (writeback serialisation)
//   line              whole line, straight from the register
module axi_line_buf
  import cache_axi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  line_t             load_line,
  input  logic              wr_en,
  input  logic [BCNT_W-1:0] wr_idx,
  input  word_t             wr_word,
  input  logic [BCNT_W-1:0] rd_idx,
  output word_t             rd_word,
  output line_t             line
);

  line_t line_q;

  // Full-line load has priority; the controller never asserts both together.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else if (load) begin
      line_q <= load_line;
    end else if (wr_en) begin
      line_q[wr_idx] <= wr_word;
    end
  end

  assign rd_word = line_q[rd_idx];
  assign line    = line_q;

endmodule

// File: rtl/cache_axi_arbiter.sv
// Arbitrates ICache refill, DCache refill and DCache writeback onto the
// single cache-side port of the AXI bus interface. One transaction at a
// time; reads assemble 8 beats into a line, writes serialise a line into
// 8 words paced by the per-beat write response.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   icache_rreq/raddr/rvalid/rdata ICache refill request and returned line
//   dcache_rreq/raddr/rvalid/rdata DCache refill request and returned line
//   dcache_wreq/waddr/wdata/wdone  DCache writeback request and completion
//   axi_ce/ren/wen/raddr/waddr     request strobes and burst addresses
//   axi_wdata/wsel/wvalid/wlast    write beat
//   axi_rready                     read beat acceptance
//   axi_rlen/wlen/burst_type/size  fixed burst attributes
//   rdata_i, rdata_valid_i         returned read beat
//   wdata_resp_i                   write beat accepted
module cache_axi_arbiter
  import cache_axi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,

  input  logic              icache_rreq,
  input  logic [ADDR_W-1:0] icache_raddr,
  output logic              icache_rvalid,
  output logic [LINE_W-1:0] icache_rdata,

  input  logic              dcache_rreq,
  input  logic [ADDR_W-1:0] dcache_raddr,
  output logic              dcache_rvalid,
  output logic [LINE_W-1:0] dcache_rdata,

  input  logic              dcache_wreq,
  input  logic [ADDR_W-1:0] dcache_waddr,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic              dcache_wdone,

  output logic              axi_ce,
  output logic              axi_ren,
  output logic              axi_wen,
  output logic [ADDR_W-1:0] axi_raddr,
  output logic [ADDR_W-1:0] axi_waddr,
  output logic [WORD_W-1:0] axi_wdata,
  output logic [3:0]        axi_wsel,
  output logic              axi_rready,
  output logic              axi_wvalid,
  output logic              axi_wlast,
  output logic [7:0]        axi_rlen,
  output logic [7:0]        axi_wlen,
  output logic [1:0]        axi_burst_type,
  output logic [2:0]        axi_burst_size,

  input  logic [WORD_W-1:0] rdata_i,
  input  logic              rdata_valid_i,
  input  logic              wdata_resp_i
);

  state_e            state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  req_id_e           id_q, id_d;

  logic              axi_ce_d, axi_ren_d, axi_wen_d, axi_rready_d;
  logic [ADDR_W-1:0] axi_raddr_d, axi_waddr_d;
  logic              axi_wvalid_d, axi_wlast_d;
  logic [WORD_W-1:0] axi_wdata_d;
  logic              icache_rvalid_d, dcache_rvalid_d, dcache_wdone_d;

  logic              buf_load, buf_wr_en;
  word_t             buf_rd_word;
  line_t             buf_line;

  // Fixed burst attributes.
  assign axi_wsel       = WSEL_ALL;
  assign axi_rlen       = BURST_LEN;
  assign axi_wlen       = BURST_LEN;
  assign axi_burst_type = BURST_INCR;
  assign axi_burst_size = SIZE_4B;

  // Both refill ports see the assembled line; rvalid qualifies which one owns it.
  assign icache_rdata = buf_line;
  assign dcache_rdata = buf_line;

  axi_line_buf u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_line (line_t'(dcache_wdata)),
    .wr_en     (buf_wr_en),
    .wr_idx    (bcnt_q),
    .wr_word   (rdata_i),
    .rd_idx    (bcnt_d),
    .rd_word   (buf_rd_word),
    .line      (buf_line)
  );

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bcnt_q        <= '0;
      gap_q         <= '0;
      id_q          <= REQ_ICACHE;
      axi_ce        <= 1'b0;
      axi_ren       <= 1'b0;
      axi_wen       <= 1'b0;
      axi_raddr     <= '0;
      axi_waddr     <= '0;
      axi_rready    <= 1'b0;
      axi_wvalid    <= 1'b0;
      axi_wlast     <= 1'b0;
      axi_wdata     <= '0;
      icache_rvalid <= 1'b0;
      dcache_rvalid <= 1'b0;
      dcache_wdone  <= 1'b0;
    end else begin
      state_q       <= state_d;
      bcnt_q        <= bcnt_d;
      gap_q         <= gap_d;
      id_q          <= id_d;
      axi_ce        <= axi_ce_d;
      axi_ren       <= axi_ren_d;
      axi_wen       <= axi_wen_d;
      axi_raddr     <= axi_raddr_d;
      axi_waddr     <= axi_waddr_d;
      axi_rready    <= axi_rready_d;
      axi_wvalid    <= axi_wvalid_d;
      axi_wlast     <= axi_wlast_d;
      axi_wdata     <= axi_wdata_d;
      icache_rvalid <= icache_rvalid_d;
      dcache_rvalid <= dcache_rvalid_d;
      dcache_wdone  <= dcache_wdone_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that they are registered while still lining up with the state.
  always_comb begin
    state_d         = state_q;
    bcnt_d          = bcnt_q;
    gap_d           = gap_q;
    id_d            = id_q;
    buf_load        = 1'b0;
    buf_wr_en       = 1'b0;
    axi_ce_d        = 1'b0;
    axi_ren_d       = 1'b0;
    axi_wen_d       = 1'b0;
    axi_raddr_d     = '0;
    axi_waddr_d     = '0;
    axi_rready_d    = 1'b0;
    icache_rvalid_d = 1'b0;
    dcache_rvalid_d = 1'b0;
    dcache_wdone_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Writeback first so a refill of the same line never reads stale memory.
        if (dcache_wreq) begin
          state_d     = ST_WR_REQ;
          id_d        = REQ_DCACHE;
          bcnt_d      = '0;
          buf_load    = 1'b1;
          axi_ce_d    = 1'b1;
          axi_wen_d   = 1'b1;
          axi_waddr_d = dcache_waddr;
        end else if (dcache_rreq) begin
          state_d     = ST_RD_REQ;
          id_d        = REQ_DCACHE;
          bcnt_d      = '0;
          axi_ce_d    = 1'b1;
          axi_ren_d   = 1'b1;
          axi_raddr_d = dcache_raddr;
        end else if (icache_rreq) begin
          state_d     = ST_RD_REQ;
          id_d        = REQ_ICACHE;
          bcnt_d      = '0;
          axi_ce_d    = 1'b1;
          axi_ren_d   = 1'b1;
          axi_raddr_d = icache_raddr;
        end
      end

      ST_RD_REQ: state_d = ST_RD_DATA;

      ST_RD_DATA: begin
        if (rdata_valid_i) begin
          buf_wr_en = 1'b1;
          if (bcnt_q == LAST_BEAT) begin
            state_d         = ST_DONE;
            gap_d           = '0;
            icache_rvalid_d = (id_q == REQ_ICACHE);
            dcache_rvalid_d = (id_q == REQ_DCACHE);
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end

      ST_WR_REQ: state_d = ST_WR_DATA;

      ST_WR_DATA: begin
        if (wdata_resp_i) begin
          if (bcnt_q == LAST_BEAT) begin
            state_d        = ST_DONE;
            gap_d          = '0;
            dcache_wdone_d = 1'b1;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end

      // Give the bus interface time to return to idle before the next strobe.
      ST_DONE: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    axi_rready_d = (state_d == ST_RD_DATA);
  end

  // Write beat presented from the line buffer at the next beat index.
  always_comb begin
    axi_wvalid_d = 1'b0;
    axi_wdata_d  = '0;
    axi_wlast_d  = 1'b0;
    if (state_d == ST_WR_DATA) begin
      axi_wvalid_d = 1'b1;
      axi_wdata_d  = buf_rd_word;
      axi_wlast_d  = (bcnt_d == LAST_BEAT);
    end
  end

endmodule

// File: doc/cache_axi_arbiter.md
# cache_axi_arbiter

Sits directly upstream of the AXI bus interface. It arbitrates ICache refill, DCache refill and DCache writeback requests onto that interface's single cache-side port. Reads are 8-beat bursts assembled into a 256-bit line. Writebacks serialise a 256-bit line into 8 words, paced by the per-beat write response. One transaction is in flight at a time.

## Interface
- LINE_WORDS, 8: words per cache line; burst lengths are LINE_WORDS-1.
- IDLE_GAP, 2: cycles held in DONE before the next request is issued, so the bus interface can return to idle.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- icache_rreq  in  1  refill request, level, held until icache_rvalid
- icache_raddr  in  32  line address
- icache_rvalid  out  1  one-cycle pulse: line returned
- icache_rdata  out  256  refill line
- dcache_rreq, dcache_raddr, dcache_rvalid, dcache_rdata: same semantics as the ICache ports, for the DCache
- dcache_wreq  in  1  writeback request, level, held until dcache_wdone
- dcache_waddr  in  32  writeback address
- dcache_wdata  in  256  writeback line, stable while dcache_wreq is high
- dcache_wdone  out  1  one-cycle pulse: writeback finished
- axi_ce, axi_ren, axi_wen  out  1  request strobes to the bus interface
- axi_raddr, axi_waddr  out  32  burst start addresses
- axi_wdata  out  32  current write word
- axi_wsel  out  4  fixed 4'b1111
- axi_rready  out  1  high in RD_DATA
- axi_wvalid, axi_wlast  out  1  write beat valid / last beat
- axi_rlen, axi_wlen  out  8  fixed 8'd7
- axi_burst_type  out  2  fixed 2'b01 (INCR)
- axi_burst_size  out  3  fixed 3'b010 (4 bytes)
- rdata_i  in  32  returned read beat
- rdata_valid_i  in  1  read beat valid
- wdata_resp_i  in  1  write beat accepted

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, DONE.
- IDLE priority: dcache_wreq > dcache_rreq > icache_rreq. Writeback goes first so a refill of the same line never reads stale memory. The winner's ID (I/D) is latched.
- RD_REQ:
  - axi_ce=axi_ren=1 for exactly one cycle, with axi_raddr = latched address.
  - Next state is RD_DATA.
- RD_DATA:
  - Each rdata_valid_i cycle writes rdata_i into word[bcnt], i.e. line bits [32*bcnt+31 : 32*bcnt], then bcnt++.
  - Beat 0 is the lowest address.
  - On the beat with bcnt==7, go to DONE and pulse the winner's rvalid; rdata is presented with the full line.
- WR_REQ:
  - axi_ce=axi_wen=1 for one cycle, with axi_waddr latched.
  - The line is captured from dcache_wdata into the internal buffer.
- WR_DATA:
  - axi_wvalid=1, axi_wdata = word[bcnt], axi_wlast = (bcnt==7).
  - Each wdata_resp_i advances bcnt.
  - The resp with bcnt==7 goes to DONE and pulses dcache_wdone.
- DONE: held IDLE_GAP cycles, then IDLE. The rvalid/wdone pulse occurs on the first DONE cycle only.
- rdata_valid_i outside RD_DATA and wdata_resp_i outside WR_DATA are ignored.
- bcnt is 3 bits, cleared on entry to RD_REQ/WR_REQ. It cannot wrap within a transaction.
- Request held high after done: re-arbitrated as a new transaction. Requesters must drop it on the done pulse.

## Timing
- Reset values: all outputs 0, except the fixed-value outputs (axi_wsel, axi_rlen, axi_wlen, axi_burst_type, axi_burst_size), which are constant. State=IDLE, bcnt=0, line buffer=0.
- All outputs are registered.
- Request seen in IDLE at cycle t: strobe at t+1.
- Read completion: the 8th rdata_valid_i at cycle n gives rvalid at n+1.
- Write completion: the 8th wdata_resp_i at n gives wdone at n+1.
- Minimum spacing between strobes of back-to-back transactions: 1 + IDLE_GAP cycles after the done pulse.
- Simultaneous requests: a loser keeps its level request and is served after the winner's DONE.
- rst mid-transaction: the next cycle is IDLE with outputs at reset values. No done pulse. The in-flight transfer is abandoned and requesters reissue.

## Structure
- Package cache_axi_pkg: state enum; LINE_WORDS; BURST_INCR=2'b01; SIZE_4B=3'b010; BURST_LEN=8'd7; requester ID enum.
- One sub-module, axi_line_buf: 256-bit register with word-indexed 32-bit write, full-line load, and a word-indexed read mux.

## Test plan
- ICache refill of 0x1C000040, beats 0x11..0x88 with no gaps: one axi_ce/axi_ren pulse. icache_rvalid pulses once. icache_rdata = {0x88,…,0x11} (word 0 = 0x11).
- DCache refill with rdata_valid_i gaps of 0–3 cycles between beats: line correct, no early dcache_rvalid.
- DCache writeback of 0x00001000 with words 0xA0..0xA7, wdata_resp_i every 2nd cycle: axi_wdata steps A0→A7. axi_wlast only on A7. dcache_wdone one cycle after the 8th resp.
- Same-cycle dcache_wreq, dcache_rreq and icache_rreq: serviced in order write, D-read, I-read. Strobes are ≥1+IDLE_GAP cycles apart.
- rst asserted after beat 4 of a read: no rvalid. Next cycle all outputs are 0. A new request issues a fresh strobe with bcnt restarting at 0.
- Spurious rdata_valid_i and wdata_resp_i in IDLE: no state change, no output change.
